// File: rtl/hw_pointer_wb_pkg.sv
// Shared types and helpers for the hardware-pointer writeback TLP source.
package hw_pointer_wb_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned REM_W  = 8;
    localparam int unsigned PTR_W  = 64;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned ID_W   = 16;

    localparam logic [6:0] MEM_WR32_FMT_TYPE = 7'h40;
    localparam logic [6:0] MEM_WR64_FMT_TYPE = 7'h60;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_BEAT0 = 3'd2,
        ST_BEAT1 = 3'd3,
        ST_BEAT2 = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

    // First header DW of a memory-write request
    typedef struct packed {
        logic       rsvd0;
        logic [6:0] fmt_type;
        logic       rsvd1;
        logic [2:0] tc;
        logic [3:0] rsvd2;
        logic       td;
        logic       ep;
        logic [1:0] attr;
        logic [1:0] rsvd3;
        logic [9:0] length;
    } tlp_dw0_t;

    function automatic tlp_dw0_t mwr_dw0(input logic is32);
        tlp_dw0_t h;
        h          = '0;
        h.fmt_type = is32 ? MEM_WR32_FMT_TYPE : MEM_WR64_FMT_TYPE;
        h.length   = 10'd2;
        return h;
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/hw_pointer_wb_if.sv
// TRN transmit bus between a TLP source (master) and the PCIe core (slave).
interface hw_pointer_wb_if;
    import hw_pointer_wb_pkg::*;

    logic [DATA_W-1:0] trn_td;
    logic [REM_W-1:0]  trn_trem_n;
    logic              trn_tsof_n;
    logic              trn_teof_n;
    logic              trn_tsrc_rdy_n;
    logic              trn_tdst_rdy_n;

    modport master (
        output trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
        input  trn_tdst_rdy_n
    );

    modport slave (
        input  trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
        output trn_tdst_rdy_n
    );
endinterface

// File: rtl/hw_pointer_wb.sv
// Writes the hardware ring pointer into a host mailbox with a posted MWr TLP.
// Optional HW_POINTER_WB_MWR32_EN: use 3DW MWr32 when the mailbox is below 4 GB.
module hw_pointer_wb
    import hw_pointer_wb_pkg::*;
#(
    parameter int unsigned HOLDOFF_CYCLES = 64,
    parameter logic [7:0]  TAG            = 8'h00
) (
    input  logic               trn_clk,
    input  logic               reset_n,
    hw_pointer_wb_if.master    tx,
    input  logic [ID_W-1:0]    cfg_completer_id,
    input  logic               my_turn,
    output logic               driven,
    input  logic               wb_enable,
    input  logic [ADDR_W-1:0]  host_wb_addr,
    input  logic [PTR_W-1:0]   hw_pointer,
    input  logic               wb_req,
    output logic               wb_done
);

    localparam int unsigned CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    state_t              state_q, state_d;
    logic                pending_q, pending_d;
    logic [PTR_W-1:0]    last_ptr_q, last_ptr_d;
    logic [PTR_W-1:0]    ptr_snap_q, ptr_snap_d;
    logic [ADDR_W-1:2]   addr_snap_q, addr_snap_d;
    logic                use32_q, use32_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   td_q, td_d;
    logic [REM_W-1:0]    rem_n_q, rem_n_d;
    logic                sof_n_q, sof_n_d;
    logic                eof_n_q, eof_n_d;
    logic                src_rdy_n_q, src_rdy_n_d;
    logic                driven_d, wb_done_d;

    logic                xfer_c, snap_c, use32_c;
    logic [DATA_W-1:0]   beat0_c, beat1_c, beat2_c;
    logic                unused_addr_lsb_c;

    // Address LSBs are always sent as zero
    assign unused_addr_lsb_c = ^host_wb_addr[1:0];

`ifdef HW_POINTER_WB_MWR32_EN
    assign use32_c = (host_wb_addr[ADDR_W-1:32] == 32'h0);
`else
    assign use32_c = 1'b0;
`endif

    assign xfer_c  = !src_rdy_n_q && !tx.trn_tdst_rdy_n;
    assign beat0_c = {mwr_dw0(use32_c), cfg_completer_id, TAG, 4'hF, 4'hF};
    assign beat1_c = use32_q ? {addr_snap_q[31:2], 2'b00, bswap32(ptr_snap_q[31:0])}
                             : {addr_snap_q[63:32], addr_snap_q[31:2], 2'b00};
    assign beat2_c = use32_q ? {bswap32(ptr_snap_q[63:32]), 32'h0}
                             : {bswap32(ptr_snap_q[31:0]), bswap32(ptr_snap_q[63:32])};

    assign tx.trn_td         = td_q;
    assign tx.trn_trem_n     = rem_n_q;
    assign tx.trn_tsof_n     = sof_n_q;
    assign tx.trn_teof_n     = eof_n_q;
    assign tx.trn_tsrc_rdy_n = src_rdy_n_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        last_ptr_d  = last_ptr_q;
        ptr_snap_d  = ptr_snap_q;
        addr_snap_d = addr_snap_q;
        use32_d     = use32_q;
        cnt_d       = cnt_q;
        td_d        = td_q;
        rem_n_d     = rem_n_q;
        sof_n_d     = sof_n_q;
        eof_n_d     = eof_n_q;
        src_rdy_n_d = src_rdy_n_q;
        driven_d    = driven;
        wb_done_d   = 1'b0;
        snap_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pending_q && wb_enable) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (my_turn) begin
                    snap_c      = 1'b1;
                    ptr_snap_d  = hw_pointer;
                    addr_snap_d = host_wb_addr[ADDR_W-1:2];
                    last_ptr_d  = hw_pointer;
                    use32_d     = use32_c;
                    td_d        = beat0_c;
                    rem_n_d     = 8'h00;
                    sof_n_d     = 1'b0;
                    src_rdy_n_d = 1'b0;
                    driven_d    = 1'b1;
                    state_d     = ST_BEAT0;
                end else if (!wb_enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BEAT0: begin
                if (xfer_c) begin
                    td_d    = beat1_c;
                    sof_n_d = 1'b1;
                    state_d = ST_BEAT1;
                end
            end
            ST_BEAT1: begin
                if (xfer_c) begin
                    td_d    = beat2_c;
                    eof_n_d = 1'b0;
                    rem_n_d = use32_q ? 8'h0F : 8'h00;
                    state_d = ST_BEAT2;
                end
            end
            ST_BEAT2: begin
                if (xfer_c) begin
                    td_d        = '0;
                    rem_n_d     = 8'hFF;
                    eof_n_d     = 1'b1;
                    src_rdy_n_d = 1'b1;
                    driven_d    = 1'b0;
                    wb_done_d   = 1'b1;
                    cnt_d       = CNT_W'(HOLDOFF_CYCLES - 1);
                    state_d     = (HOLDOFF_CYCLES > 0) ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        // A request arriving on the snapshot cycle is kept for the next TLP
        if (snap_c) pending_d = wb_req;
        else        pending_d = pending_q | wb_req | (wb_enable && (hw_pointer != last_ptr_q));
    end

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            last_ptr_q  <= '0;
            ptr_snap_q  <= '0;
            addr_snap_q <= '0;
            use32_q     <= 1'b0;
            cnt_q       <= '0;
            td_q        <= '0;
            rem_n_q     <= 8'hFF;
            sof_n_q     <= 1'b1;
            eof_n_q     <= 1'b1;
            src_rdy_n_q <= 1'b1;
            driven      <= 1'b0;
            wb_done     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            last_ptr_q  <= last_ptr_d;
            ptr_snap_q  <= ptr_snap_d;
            addr_snap_q <= addr_snap_d;
            use32_q     <= use32_d;
            cnt_q       <= cnt_d;
            td_q        <= td_d;
            rem_n_q     <= rem_n_d;
            sof_n_q     <= sof_n_d;
            eof_n_q     <= eof_n_d;
            src_rdy_n_q <= src_rdy_n_d;
            driven      <= driven_d;
            wb_done     <= wb_done_d;
        end
    end

endmodule

// File: tb/tb_hw_pointer_wb.sv
// Directed bench for hw_pointer_wb: framing, backpressure, holdoff coalescing, reset.
module tb_hw_pointer_wb;

    logic        trn_clk;
    logic        reset_n;
    logic [15:0] cfg_completer_id;
    logic        my_turn;
    logic        driven;
    logic        wb_enable;
    logic [63:0] host_wb_addr;
    logic [63:0] hw_pointer;
    logic        wb_req;
    logic        wb_done;

    hw_pointer_wb_if tx();

    hw_pointer_wb #(.HOLDOFF_CYCLES(64), .TAG(8'h00)) dut (
        .trn_clk          (trn_clk),
        .reset_n          (reset_n),
        .tx               (tx),
        .cfg_completer_id (cfg_completer_id),
        .my_turn          (my_turn),
        .driven           (driven),
        .wb_enable        (wb_enable),
        .host_wb_addr     (host_wb_addr),
        .hw_pointer       (hw_pointer),
        .wb_req           (wb_req),
        .wb_done          (wb_done)
    );

    typedef struct {
        logic [63:0] td;
        logic [7:0]  rem;
        logic        sof_n;
        logic        eof_n;
        int          cyc;
    } beat_t;

    beat_t bq[$];
    int    cyc       = 0;
    int    done_cnt  = 0;
    int    done_cyc  = 0;
    int    drv_err   = 0;
    int    stab_err  = 0;
    int    n_checks  = 0;
    int    n_fail    = 0;

    initial begin
        trn_clk = 1'b0;
        forever #5 trn_clk = ~trn_clk;
    end

    initial forever begin
        @(posedge trn_clk);
        cyc++;
    end

    // Beat capture, driven coverage of beats and stall stability, sampled mid-cycle
    initial begin
        logic        prev_stall;
        logic [74:0] prev_vec;
        logic [74:0] vec;
        prev_stall = 1'b0;
        prev_vec   = '0;
        forever begin
            @(negedge trn_clk);
            vec = {tx.trn_td, tx.trn_trem_n, tx.trn_tsof_n, tx.trn_teof_n, tx.trn_tsrc_rdy_n};
            if (reset_n) begin
                if (!tx.trn_tsrc_rdy_n && !tx.trn_tdst_rdy_n)
                    bq.push_back('{td: tx.trn_td, rem: tx.trn_trem_n, sof_n: tx.trn_tsof_n,
                                   eof_n: tx.trn_teof_n, cyc: cyc});
                if (!tx.trn_tsrc_rdy_n && !driven) drv_err++;
                if (prev_stall && vec != prev_vec) stab_err++;
                if (wb_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_stall = !tx.trn_tsrc_rdy_n && tx.trn_tdst_rdy_n;
            end else begin
                prev_stall = 1'b0;
            end
            prev_vec = vec;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge trn_clk);
        #1;
    endtask

    task automatic expect_tlp(input string tag, input logic [63:0] d0, input logic [63:0] d1,
                              input logic [63:0] d2, input logic [7:0] rem,
                              output int sof_cyc, output int eof_cyc);
        int w;
        beat_t b0, b1, b2;
        w = 0;
        while (bq.size() < 3 && w < 400) begin
            tick(1);
            w++;
        end
        check_val({tag, "_arrived"}, 64'(bq.size() >= 3), 64'd1);
        sof_cyc = 0;
        eof_cyc = 0;
        if (bq.size() >= 3) begin
            b0 = bq.pop_front();
            b1 = bq.pop_front();
            b2 = bq.pop_front();
            sof_cyc = b0.cyc;
            eof_cyc = b2.cyc;
            check_val({tag, "_beat0"}, b0.td, d0);
            check_val({tag, "_beat1"}, b1.td, d1);
            check_val({tag, "_beat2"}, b2.td, d2);
            check_val({tag, "_sof_n"}, 64'({b0.sof_n, b1.sof_n, b2.sof_n}), 64'(3'b011));
            check_val({tag, "_eof_n"}, 64'({b0.eof_n, b1.eof_n, b2.eof_n}), 64'(3'b110));
            check_val({tag, "_trem_n"}, 64'(b2.rem), 64'(rem));
        end
    endtask

    localparam logic [63:0] HDR64 = {32'h60000002, 16'hABCD, 8'h00, 8'hFF};
    localparam logic [63:0] ADDR1 = 64'h00000001_23456780;

    initial begin
        int p0, s0, e0, s1, e1, w;
        logic found;

        reset_n          = 1'b0;
        tx.trn_tdst_rdy_n = 1'b0;
        my_turn          = 1'b1;
        wb_enable        = 1'b1;
        host_wb_addr     = 64'h0000_0001_2345_6780;
        cfg_completer_id = 16'hABCD;
        hw_pointer       = 64'h0;
        wb_req           = 1'b0;
        tick(3);

        check_val("rst_td",     tx.trn_td,                 64'h0);
        check_val("rst_trem_n", 64'(tx.trn_trem_n),        64'hFF);
        check_val("rst_sof_n",  64'(tx.trn_tsof_n),        64'd1);
        check_val("rst_eof_n",  64'(tx.trn_teof_n),        64'd1);
        check_val("rst_src_n",  64'(tx.trn_tsrc_rdy_n),    64'd1);
        check_val("rst_driven", 64'(driven),               64'd0);
        check_val("rst_done",   64'(wb_done),              64'd0);

        reset_n = 1'b1;
        tick(5);
        check_val("idle_quiet", 64'(bq.size()), 64'd0);

        // Basic 4DW write with minimum latency
        p0 = cyc;
        hw_pointer = 64'h10;
        expect_tlp("t1", HDR64, ADDR1, 64'h10000000_00000000, 8'h00, s0, e0);
        check_val("t1_latency", 64'(s0 - p0), 64'd3);
        tick(2);
        check_val("t1_done_cnt", 64'(done_cnt), 64'd1);
        check_val("t1_done_cyc", 64'(done_cyc - e0), 64'd1);
        check_val("t1_driven_low", 64'(driven), 64'd0);

        // Backpressure: core ready every other cycle
        tick(70);
        hw_pointer = 64'h0102030405060708;
        for (int i = 0; i < 40; i++) begin
            tx.trn_tdst_rdy_n = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick(1);
        end
        tx.trn_tdst_rdy_n = 1'b0;
        check_val("t2_xfers", 64'(bq.size()), 64'd3);
        expect_tlp("t2", HDR64, ADDR1, 64'h08070605_04030201, 8'h00, s0, e0);
        check_val("t2_stable", 64'(stab_err), 64'd0);

        // Pointer churn during holdoff coalesces into one TLP
        tick(70);
        hw_pointer = 64'h20;
        expect_tlp("t3a", HDR64, ADDR1, 64'h20000000_00000000, 8'h00, s0, e0);
        for (int k = 1; k <= 5; k++) begin
            hw_pointer = 64'(k * 256);
            tick(5);
        end
        expect_tlp("t3b", HDR64, ADDR1, 64'h00050000_00000000, 8'h00, s1, e1);
        check_val("t3_gap", 64'((s1 - e0) >= 64), 64'd1);
        tick(100);
        check_val("t3_single", 64'(bq.size()), 64'd0);

        // Forced writeback with unchanged pointer
        wb_req = 1'b1;
        tick(1);
        wb_req = 1'b0;
        expect_tlp("t4", HDR64, ADDR1, 64'h00050000_00000000, 8'h00, s0, e0);

        // Request while disabled waits for enable
        tick(70);
        wb_enable = 1'b0;
        wb_req = 1'b1;
        tick(1);
        wb_req = 1'b0;
        tick(100);
        check_val("t5_blocked", 64'(bq.size()), 64'd0);
        wb_enable = 1'b1;
        expect_tlp("t5", HDR64, ADDR1, 64'h00050000_00000000, 8'h00, s0, e0);
        tick(100);
        check_val("t5_single", 64'(bq.size()), 64'd0);

        // Request coinciding with the EOF transfer is retained
        hw_pointer = 64'h600;
        found = 1'b0;
        w = 0;
        while (!found && w < 50) begin
            if (!tx.trn_tsrc_rdy_n && !tx.trn_teof_n) found = 1'b1;
            else begin
                tick(1);
                w++;
            end
        end
        check_val("t6_eof_seen", 64'(found), 64'd1);
        wb_req = 1'b1;
        tick(1);
        wb_req = 1'b0;
        expect_tlp("t6a", HDR64, ADDR1, 64'h00060000_00000000, 8'h00, s0, e0);
        expect_tlp("t6b", HDR64, ADDR1, 64'h00060000_00000000, 8'h00, s1, e1);
        check_val("t6_gap", 64'((s1 - e0) >= 64), 64'd1);

        // Reset during BEAT1 abandons the TLP; pointer re-triggers after release
        tick(70);
        hw_pointer = 64'h77;
        found = 1'b0;
        w = 0;
        while (!found && w < 50) begin
            if (!tx.trn_tsrc_rdy_n && tx.trn_tsof_n && tx.trn_teof_n) found = 1'b1;
            else begin
                tick(1);
                w++;
            end
        end
        check_val("t7_beat1_seen", 64'(found), 64'd1);
        reset_n = 1'b0;
        #1;
        check_val("t7_rst_td",     tx.trn_td,              64'h0);
        check_val("t7_rst_src_n",  64'(tx.trn_tsrc_rdy_n), 64'd1);
        check_val("t7_rst_trem_n", 64'(tx.trn_trem_n),     64'hFF);
        check_val("t7_rst_driven", 64'(driven),            64'd0);
        tick(2);
        bq.delete();
        reset_n = 1'b1;
        expect_tlp("t7", HDR64, ADDR1, 64'h77000000_00000000, 8'h00, s0, e0);

`ifdef HW_POINTER_WB_MWR32_EN
        // Mailbox below 4 GB uses the 3DW form
        tick(70);
        host_wb_addr = 64'h0000_0000_8000_0040;
        hw_pointer   = 64'h1122334455667788;
        expect_tlp("t8", {32'h40000002, 16'hABCD, 8'h00, 8'hFF}, 64'h80000040_88776655,
                   64'h44332211_00000000, 8'h0F, s0, e0);
`endif

        check_val("driven_cover", 64'(drv_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hw_pointer_wb.md
# hw_pointer_wb

Transmit-side counterpart of the host-pointer synchronisation path: writes the hardware ring pointer into a host-memory mailbox with a posted PCIe memory-write TLP on the TRN transmit interface. Sits beside the other TRN TX sources behind the TX arbiter (my_turn/driven handshake). Emits a write when the pointer has moved since the last writeback or on explicit request, with a programmable holdoff to bound TLP rate.

## Interface
- HOLDOFF_CYCLES, 64: minimum trn_clk cycles from one TLP's EOF beat to the next TLP's SOF beat; 0 disables holdoff.
- TAG, 8'h00: TLP tag field.
- trn_clk  in  1  TRN clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- trn_td  out  64  TX data.
- trn_trem_n  out  8  TX remainder, active low.
- trn_tsof_n / trn_teof_n / trn_tsrc_rdy_n  out  1 each  TX framing, active low.
- trn_tdst_rdy_n  in  1  core ready, active low.
- cfg_completer_id  in  16  requester ID inserted in header DW1.
- my_turn  in  1  arbiter grant.
- driven  out  1  high from grant acceptance through the EOF beat transfer.
- wb_enable  in  1  writeback enabled (host address valid).
- host_wb_addr  in  64  mailbox byte address; bits [1:0] ignored, sent as 0.
- hw_pointer  in  64  current hardware pointer.
- wb_req  in  1  single-cycle forced-writeback request (e.g. from resend-interrupt logic).
- wb_done  out  1  one-cycle pulse when the EOF beat transfers.

## Operation
- Beat transfers when trn_tsrc_rdy_n=0 and trn_tdst_rdy_n=0.
- pending flag: set by wb_req (sticky), or when wb_enable and hw_pointer != last_ptr; cleared on snapshot.
- States: IDLE, ARB, BEAT0, BEAT1, BEAT2, HOLD.
- IDLE: pending and wb_enable -> ARB. wb_req while wb_enable=0 stays pending.
- ARB: my_turn=1 -> snapshot ptr_snap<=hw_pointer, addr_snap<=host_wb_addr, last_ptr<=hw_pointer, assert driven -> BEAT0.
- 4DW MWr64 (Fmt/Type 7'h60, TC 0, attr 0, Length 2): BEAT0 td={DW0,DW1}, tsof_n=0; DW1={cfg_completer_id,TAG,4'hF,4'hF}. BEAT1 td={addr_snap[63:32],addr_snap[31:2],2'b00}. BEAT2 td={bswap32(ptr_snap[31:0]),bswap32(ptr_snap[63:32])}, teof_n=0, trem_n=8'h00.
- bswap32 reverses bytes within the DW (host little-endian; byte 0 of pointer in td[63:56]).
- After BEAT2 transfer: wb_done pulse, driven=0; -> HOLD if HOLDOFF_CYCLES>0, else IDLE.
- HOLD: counter counts HOLDOFF_CYCLES-1 down to 0 -> IDLE. Pointer changes/wb_req during HOLD keep pending set; no loss, coalesced into one TLP.
- Pointer changes between snapshot and EOF: sent value is snapshot; new value re-triggers afterwards.
- wb_enable deasserting after ARB grant does not abort the TLP.

## Timing
- Reset values: trn_td=0, trn_trem_n=8'hFF, trn_tsof_n=trn_teof_n=trn_tsrc_rdy_n=1, driven=0, wb_done=0; FSM IDLE, pending=0, last_ptr=0, counter=0.
- All outputs registered. Minimum latency: pending set at cycle N -> ARB at N+1 -> with my_turn at N+1, SOF presented at N+2.
- tsrc_rdy_n held low continuously BEAT0..BEAT2; outputs stable while trn_tdst_rdy_n=1.
- Simultaneous wb_req and EOF transfer: request retained, new TLP after holdoff.
- Reset asserted mid-TLP: immediate return to reset values, partial TLP abandoned (core reset concurrently).

## Configuration
- HW_POINTER_WB_MWR32_EN defined: if addr_snap[63:32]==0, send 3DW MWr32 (Fmt/Type 7'h40): BEAT0 as above, BEAT1 td={addr_snap[31:2],2'b00,bswap32(ptr_snap[31:0])}, BEAT2 td={bswap32(ptr_snap[63:32]),32'h0}, trem_n=8'h0F. Upper address nonzero -> 4DW form.
- Undefined: 4DW form always; driver guarantees mailbox above 4 GB.

## Structure
- Shared package/include: MEM_WR32_FMT_TYPE, MEM_WR64_FMT_TYPE, state encodings, bswap32 function.
- Single module; no sub-module (holdoff counter inline).

## Test plan
- wb_enable=1, hw_pointer 0->0x0000_0000_0000_0010, addr 0x1_2345_6780, my_turn=1, tdst_rdy always -> 3 beats: {0x60000002,id&0x000000FF}, {0x00000001,0x23456780}, {0x10000000,0x00000000}; wb_done after beat 3.
- trn_tdst_rdy_n toggled every other cycle -> beat data/framing held stable, exactly 3 transfers.
- Pointer changes 5 times during HOLD (HOLDOFF_CYCLES=64) -> exactly one further TLP carrying last value, SOF ≥64 cycles after prior EOF.
- wb_req with unchanged pointer -> TLP sent; wb_req with wb_enable=0 -> nothing until wb_enable=1, then one TLP.
- MWR32_EN, addr 0x0000_0000_8000_0040 -> Fmt/Type 0x40, BEAT1 low DW = bswap of ptr low, trem_n=8'h0F.
- reset_n low during BEAT1 -> outputs to reset values same cycle; after release, pending pointer change produces full TLP.
